// File: rtl/pulse_deser_pkg.sv
// pulse_deser_pkg: shared FSM state type, default word width and counter-width helper
// for the pulse deserializer.
package pulse_deser_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// deser_shift_reg: serial-to-parallel shift register with a frame bit counter.
// last_o flags that the bit sampled on this edge is the final data bit of the frame.
module deser_shift_reg
    import pulse_deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sample_i,
    input  logic             first_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] word_d_o,
    output logic             last_o
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    logic [WIDTH-1:0] word_q, word_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;

    generate
        if (WIDTH == 1) begin : g_one
            assign shifted = serial_i;
        end else if (MSB_FIRST) begin : g_msb
            assign shifted = {word_q[WIDTH-2:0], serial_i};
        end else begin : g_lsb
            assign shifted = {serial_i, word_q[WIDTH-1:1]};
        end
    endgenerate

    // A restarting frame overwrites every stale bit before it completes, so no clear is needed.
    always_comb begin
        last_o = sample_i && (first_i ? (WIDTH == 1) : (cnt_q == CW'(WIDTH - 1)));
        word_d = sample_i ? shifted : word_q;
        cnt_d  = !sample_i ? cnt_q : last_o ? '0 : first_i ? CW'(1) : cnt_q + CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_d_o = word_d;

endmodule

// File: rtl/pulse_deserializer.sv
// pulse_deserializer: frames a serial pulse stream into WIDTH-bit words with a valid/ready
// output, sticky overrun flag and optional even parity (macro PULSE_DESER_PARITY_EN).
module pulse_deserializer
    import pulse_deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    input  logic             clear_overrun,
    output logic             parity_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, word;
    logic             valid_q, valid_d, ovr_q, ovr_d, perr_q, perr_d;
    logic             sample, data_last, done, perr, load;

    assign sample = frame_start || (state_q == SHIFT);

    deser_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
        .clock    (clock),
        .reset_n  (reset_n),
        .sample_i (sample),
        .first_i  (frame_start),
        .serial_i (serial_in),
        .word_d_o (word),
        .last_o   (data_last)
    );

    // The shift register holds in PARITY, so word already equals the completed data bits there.
`ifdef PULSE_DESER_PARITY_EN
    localparam state_e AFTER_DATA = PARITY;
    assign done = (state_q == PARITY) && !frame_start;
    assign perr = ^word ^ serial_in;
`else
    localparam state_e AFTER_DATA = IDLE;
    assign done = data_last;
    assign perr = 1'b0;
`endif

    always_comb begin
        state_d = sample ? (data_last ? AFTER_DATA : SHIFT) : IDLE;
        load    = done && (!valid_q || data_ready);
        data_d  = load ? word : data_q;
        valid_d = load || (valid_q && !data_ready);
        ovr_d   = (done && valid_q && !data_ready) || (ovr_q && !clear_overrun);
        perr_d  = load ? perr : perr_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
    assign parity_err = perr_q;

endmodule

// File: doc/pulse_deserializer.md
PULSE_DESERIALIZER -- requirements
Module: pulse_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of data bits per word.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 means the first serial bit is data_out[WIDTH-1]; 0 means the first serial bit is data_out[0].
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port serial_in, input, 1 bit: serial pulse stream from pulse_generator, one bit per clock.
REQ-006 SHALL have port frame_start, input, 1 bit: one-cycle marker; the first bit of a frame is on serial_in in that same cycle.
REQ-007 SHALL have port data_out, output, WIDTH bits: last completed word.
REQ-008 SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed word.
REQ-009 SHALL have port data_ready, input, 1 bit: the consumer accepts data_out.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag; a completed word was dropped.
REQ-011 SHALL have port clear_overrun, input, 1 bit: synchronous clear of overrun.
REQ-012 SHALL have port parity_err, output, 1 bit: parity mismatch on the word currently on data_out.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and PARITY.
- IDLE->SHIFT on frame_start=1.
- SHIFT->IDLE after WIDTH bits, or SHIFT->PARITY when parity is enabled.
- PARITY->IDLE after one bit.
REQ-014 SHALL sample serial_in on every rising edge in SHIFT, and on the frame_start edge itself; the bit counter runs 0..WIDTH-1 with no wrap beyond WIDTH-1.
REQ-015 SHALL load data_out and set data_valid on the same edge that samples the final bit of a frame (the final data bit, or the parity bit when parity is enabled); latency is 0 cycles after that edge.
REQ-016 SHALL complete a transfer on an edge with data_valid=1 and data_ready=1; data_valid then falls on that edge unless a new word loads on the same edge.
REQ-017 SHALL hold data_out and data_valid stable while data_valid=1 and data_ready=0.
REQ-018 SHALL handle a word completing while data_valid=1 and data_ready=0 as follows: drop the new word, keep data_out unchanged, set overrun.
REQ-019 SHALL handle a word completing on the same edge as a transfer as follows: load the new word, keep data_valid=1, leave overrun unchanged.
REQ-020 SHALL handle frame_start=1 while in SHIFT or PARITY as follows: discard the partial frame, restart at bit 0 with the current serial_in, and set no flag.
REQ-021 SHALL clear overrun on clear_overrun=1; if an overrun event occurs on the same edge, set wins.
REQ-022 SHALL ignore serial_in while in IDLE.

Reset
REQ-023 SHALL, when reset_n=0 at any time (including mid-frame), immediately force the following:
- state IDLE and bit counter 0;
- data_out=0, data_valid=0, overrun=0, parity_err=0.
REQ-024 SHALL resume from reset_n release with the first rising edge at which frame_start=1.

Configuration
REQ-025 SHALL, when macro PULSE_DESER_PARITY_EN is defined, do the following:
- expect one even-parity bit after the WIDTH data bits;
- set parity_err together with data_valid when the XOR of the data bits and the parity bit is 1;
- never drop a word for a parity mismatch.
REQ-026 SHALL, when PULSE_DESER_PARITY_EN is undefined, omit the PARITY state and tie parity_err to 0.

Structure
REQ-027 SHALL take the following from shared package pulse_deser_pkg:
- the FSM state typedef (IDLE/SHIFT/PARITY);
- the DEFAULT_WIDTH=16 constant;
- the counter-width function clog2(WIDTH).
REQ-028 SHALL place the shift register and bit counter in sub-module deser_shift_reg; the FSM, output register and flags stay in the top level.

Verification
REQ-029 SHALL verify a basic word: frame_start with the bit stream 16'b0101001001010100, MSB_FIRST=1, data_ready=1 -> data_out=16'h5254 and data_valid high for exactly 1 cycle, starting on the 16th sampling edge.
REQ-030 SHALL verify backpressure: data_ready=0, send 16'h5254 then 16'hFFFF -> data_out stays 16'h5254, overrun=1; clear_overrun pulse -> overrun=0.
REQ-031 SHALL verify back-to-back frames: data_ready pulses on the edge the second word completes -> data_out becomes the second word, data_valid stays 1, overrun=0.
REQ-032 SHALL verify an aborted frame: frame_start at bit 7, then 16'h00F0 -> only 16'h00F0 is delivered.
REQ-033 SHALL verify reset mid-frame: reset_n low at bit 9 -> all outputs 0 immediately; a subsequent full frame 16'hA5A5 is delivered correctly.
REQ-034 SHALL verify parity (PULSE_DESER_PARITY_EN): 16'h0001 with parity bit 0 -> parity_err=1 and word delivered; with parity bit 1 -> parity_err=0.
